// File: rtl/fpu_r4_operand_seq.sv
// Issue sequencer for R4-type binary16 FMA ops: fetches three operands over two reads,
// applies op sign flips, holds them for FMA_LAT cycles, then hands the result to writeback.
// Optional: define FPU_SEQ_CANON_NAN_EN to canonicalise NaN results to 16'h7E00 at capture.
module fpu_r4_operand_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned AW      = 5,
    parameter int unsigned FMA_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [AW-1:0]    req_rs1_i,
    input  logic [AW-1:0]    req_rs2_i,
    input  logic [AW-1:0]    req_rs3_i,
    input  logic [AW-1:0]    req_rd_i,
    output logic [AW-1:0]    rf_raddr_a_o,
    output logic [AW-1:0]    rf_raddr_b_o,
    input  logic [WIDTH-1:0] rf_rdata_a_i,
    input  logic [WIDTH-1:0] rf_rdata_b_i,
    output logic [WIDTH-1:0] fma_rs1_o,
    output logic [WIDTH-1:0] fma_rs2_o,
    output logic [WIDTH-1:0] fma_rs3_o,
    input  logic [WIDTH-1:0] fma_rd_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [AW-1:0]    wb_addr_o,
    output logic [WIDTH-1:0] wb_data_o,
    output logic             busy_o
);
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FMA_LAT - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef FPU_SEQ_CANON_NAN_EN
    localparam logic [WIDTH-1:0] CANON_NAN = WIDTH'(16'h7E00);
`endif

    typedef enum logic [2:0] {IDLE, READ_AB, READ_C, EXEC, WB} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    rs3_q, rs3_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    raddr_a_q, raddr_a_d;
    logic [AW-1:0]    raddr_b_q, raddr_b_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] op3_q, op3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic             wb_valid_q, wb_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] res_c;

    // Result as it will be stored at capture
    always_comb begin
        res_c = fma_rd_i;
`ifdef FPU_SEQ_CANON_NAN_EN
        if (fma_rd_i[14:10] == 5'h1F && fma_rd_i[9:0] != 10'h000) begin
            res_c = CANON_NAN;
        end
`endif
    end

    // Next-state and registered-output logic; sign flips are folded in when operands are latched
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs3_d       = rs3_q;
        rd_d        = rd_q;
        raddr_a_d   = raddr_a_q;
        raddr_b_d   = raddr_b_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        op3_d       = op3_q;
        cnt_d       = cnt_q;
        wb_data_d   = wb_data_q;
        wb_addr_d   = wb_addr_q;
        wb_valid_d  = wb_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d        = req_op_i;
                    rs3_d       = req_rs3_i;
                    rd_d        = req_rd_i;
                    raddr_a_d   = req_rs1_i;
                    raddr_b_d   = req_rs2_i;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = READ_AB;
                end
            end
            READ_AB: begin
                op1_d     = rf_rdata_a_i ^ (op_q[1] ? SIGN_MASK : '0);
                op2_d     = rf_rdata_b_i;
                raddr_a_d = rs3_q;
                raddr_b_d = '0;
                state_d   = READ_C;
            end
            READ_C: begin
                op3_d     = rf_rdata_a_i ^ (op_q[0] ? SIGN_MASK : '0);
                cnt_d     = '0;
                raddr_a_d = '0;
                state_d   = EXEC;
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    wb_data_d  = res_c;
                    wb_addr_d  = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    wb_valid_d  = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                wb_valid_d  = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rs3_q       <= '0;
            rd_q        <= '0;
            raddr_a_q   <= '0;
            raddr_b_q   <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            op3_q       <= '0;
            cnt_q       <= '0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs3_q       <= rs3_d;
            rd_q        <= rd_d;
            raddr_a_q   <= raddr_a_d;
            raddr_b_q   <= raddr_b_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op3_q       <= op3_d;
            cnt_q       <= cnt_d;
            wb_data_q   <= wb_data_d;
            wb_addr_q   <= wb_addr_d;
            wb_valid_q  <= wb_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rf_raddr_a_o = raddr_a_q;
    assign rf_raddr_b_o = raddr_b_q;
    assign fma_rs1_o    = op1_q;
    assign fma_rs2_o    = op2_q;
    assign fma_rs3_o    = op3_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_fpu_r4_operand_seq.sv
// Directed bench for fpu_r4_operand_seq: FMA_LAT=1 instance for op/backpressure/reset/NaN
// scenarios, and an FMA_LAT=3 instance for capture timing.
module tb_fpu_r4_operand_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] rf [32];

    logic [1:0]  req_op;
    logic [4:0]  req_rs1, req_rs2, req_rs3, req_rd;

    logic        req_valid, req_ready, wb_valid, wb_ready, busy;
    logic [4:0]  raddr_a, raddr_b, wb_addr;
    logic [15:0] rdata_a, rdata_b, fma1, fma2, fma3, fma_rd, wb_data;

    logic        req_valid3, req_ready3, wb_valid3, wb_ready3, busy3;
    logic [4:0]  raddr_a3, raddr_b3, wb_addr3;
    logic [15:0] rdata_a3, rdata_b3, fma1_3, fma2_3, fma3_3, fma_rd3, wb_data3;

    assign rdata_a  = rf[raddr_a];
    assign rdata_b  = rf[raddr_b];
    assign rdata_a3 = rf[raddr_a3];
    assign rdata_b3 = rf[raddr_b3];

    fpu_r4_operand_seq #(.WIDTH(16), .AW(5), .FMA_LAT(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rs3_i(req_rs3), .req_rd_i(req_rd),
        .rf_raddr_a_o(raddr_a), .rf_raddr_b_o(raddr_b),
        .rf_rdata_a_i(rdata_a), .rf_rdata_b_i(rdata_b),
        .fma_rs1_o(fma1), .fma_rs2_o(fma2), .fma_rs3_o(fma3), .fma_rd_i(fma_rd),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr),
        .wb_data_o(wb_data), .busy_o(busy)
    );

    fpu_r4_operand_seq #(.WIDTH(16), .AW(5), .FMA_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_op_i(req_op),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rs3_i(req_rs3), .req_rd_i(req_rd),
        .rf_raddr_a_o(raddr_a3), .rf_raddr_b_o(raddr_b3),
        .rf_rdata_a_i(rdata_a3), .rf_rdata_b_i(rdata_b3),
        .fma_rs1_o(fma1_3), .fma_rs2_o(fma2_3), .fma_rs3_o(fma3_3), .fma_rd_i(fma_rd3),
        .wb_valid_o(wb_valid3), .wb_ready_i(wb_ready3), .wb_addr_o(wb_addr3),
        .wb_data_o(wb_data3), .busy_o(busy3)
    );

    // Presents one request to the FMA_LAT=1 instance; returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] op, input logic [4:0] a, b, c, d);
        @(negedge clk);
        req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = d;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
        checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL reset_busy_valid: got %b%b exp 00", busy, wb_valid); end
        checks++; if ({raddr_a, raddr_b, wb_addr} !== 15'h0) begin failures++; $display("FAIL reset_addrs: got %h/%h/%h exp 0", raddr_a, raddr_b, wb_addr); end
        checks++; if ({fma1, fma2, fma3, wb_data} !== 64'h0) begin failures++; $display("FAIL reset_data: got %h %h %h %h exp 0", fma1, fma2, fma3, wb_data); end
    endtask

    // One op with wb_ready held high throughout, checking every cycle of the sequence
    task automatic run_op(input logic [1:0] op, input logic [15:0] res,
                          input logic [15:0] e1, e3, ed, input string name);
        fma_rd = res;
        wb_ready = 1'b1;
        issue(op, 5'd1, 5'd2, 5'd3, 5'd5);
        checks++; if (raddr_a !== 5'd1 || raddr_b !== 5'd2) begin failures++; $display("FAIL %s_read_ab: got %0d/%0d exp 1/2", name, raddr_a, raddr_b); end
        checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s_busy: got ready=%b busy=%b exp 0/1", name, req_ready, busy); end
        @(negedge clk);
        checks++; if (raddr_a !== 5'd3 || raddr_b !== 5'd0) begin failures++; $display("FAIL %s_read_c: got %0d/%0d exp 3/0", name, raddr_a, raddr_b); end
        @(negedge clk);
        checks++; if (fma1 !== e1 || fma2 !== 16'h4200 || fma3 !== e3) begin failures++; $display("FAIL %s_fma_in: got %h/%h/%h exp %h/4200/%h", name, fma1, fma2, fma3, e1, e3); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL %s_early_valid: got %b exp 0", name, wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd5 || wb_data !== ed) begin failures++; $display("FAIL %s_wb: got v=%b a=%0d d=%h exp v=1 a=5 d=%h", name, wb_valid, wb_addr, wb_data, ed); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL %s_done: got v=%b r=%b b=%b exp 0/1/0", name, wb_valid, req_ready, busy); end
    endtask

    task automatic test_fmadd();  run_op(2'b00, 16'h4700, 16'h4000, 16'h3C00, 16'h4700, "fmadd");  endtask
    task automatic test_fmsub();  run_op(2'b01, 16'h4500, 16'h4000, 16'hBC00, 16'h4500, "fmsub");  endtask
    task automatic test_fnmsub(); run_op(2'b10, 16'hC500, 16'hC000, 16'h3C00, 16'hC500, "fnmsub"); endtask
    task automatic test_fnmadd(); run_op(2'b11, 16'hC700, 16'hC000, 16'hBC00, 16'hC700, "fnmadd"); endtask

    task automatic test_backpressure();
        fma_rd = 16'h4700;
        wb_ready = 1'b0;
        issue(2'b00, 5'd1, 5'd2, 5'd3, 5'd5);
        repeat (3) @(negedge clk);
        fma_rd = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 1);
            req_rd = 5'd7;
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== 16'h4700 || wb_addr !== 5'd5 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h a=%0d r=%b exp 1/4700/5/0", i, wb_valid, wb_data, wb_addr, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got v=%b r=%b exp 0/1", wb_valid, req_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_queue: got busy=%b exp 0", busy); end
    endtask

    task automatic test_lat3();
        int first = -1;
        logic [15:0] fma_at_e4 = 16'h0;
        wb_ready3 = 1'b1;
        @(negedge clk);
        req_op = 2'b00; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rs3 = 5'd3; req_rd = 5'd9;
        req_valid3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            req_valid3 = 1'b0;
            if (wb_valid3 === 1'b1 && first < 0) first = k;
            if (k == 4) fma_at_e4 = fma1_3;
            fma_rd3 = 16'h1100 + 16'(k);
            if (first >= 0) break;
        end
        checks++; if (first != 5) begin failures++; $display("FAIL lat3_latency: got %0d exp 5", first); end
        checks++; if (wb_data3 !== 16'h1104 || wb_addr3 !== 5'd9) begin failures++; $display("FAIL lat3_capture: got %h a=%0d exp 1104 a=9", wb_data3, wb_addr3); end
        checks++; if (fma_at_e4 !== 16'h4000) begin failures++; $display("FAIL lat3_operand_hold: got %h exp 4000", fma_at_e4); end
        @(negedge clk);
        checks++; if (wb_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin failures++; $display("FAIL lat3_done: got v=%b r=%b exp 0/1", wb_valid3, req_ready3); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        fma_rd = 16'h4700;
        wb_ready = 1'b1;
        issue(2'b11, 5'd1, 5'd2, 5'd3, 5'd5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ctrl: got b=%b v=%b r=%b exp 0/0/1", busy, wb_valid, req_ready); end
        checks++; if ({fma1, fma3, wb_data} !== 48'h0 || raddr_a !== 5'd0) begin failures++; $display("FAIL rst_mid_data: got %h %h %h a=%0d exp 0", fma1, fma3, wb_data, raddr_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_wb: got pulse=%b exp 0", seen); end
        run_op(2'b00, 16'h4700, 16'h4000, 16'h3C00, 16'h4700, "after_rst");
    endtask

    task automatic test_nan();
`ifdef FPU_SEQ_CANON_NAN_EN
        run_op(2'b00, 16'h7D55, 16'h4000, 16'h3C00, 16'h7E00, "nan");
        run_op(2'b00, 16'hFD55, 16'h4000, 16'h3C00, 16'h7E00, "neg_nan");
`else
        run_op(2'b00, 16'h7D55, 16'h4000, 16'h3C00, 16'h7D55, "nan");
        run_op(2'b00, 16'hFD55, 16'h4000, 16'h3C00, 16'hFD55, "neg_nan");
`endif
        run_op(2'b00, 16'h7C00, 16'h4000, 16'h3C00, 16'h7C00, "inf");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 16'h0;
        rf[1] = 16'h4000;
        rf[2] = 16'h4200;
        rf[3] = 16'h3C00;
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid3 = 1'b0;
        wb_ready = 1'b0;  wb_ready3 = 1'b0;
        req_op = 2'b00; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rd = '0;
        fma_rd = '0; fma_rd3 = '0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_fmadd();
        test_fmsub();
        test_fnmsub();
        test_fnmadd();
        test_backpressure();
        test_lat3();
        test_reset_mid();
        test_nan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_r4_operand_seq.md
Name: fpu_r4_operand_seq

Overview:
- Upstream issue stage for the combinational 16-bit FMADD unit.
- Ibex register file has two read ports, so R4-type ops (FMADD/FMSUB/FNMSUB/FNMADD) need three source operands fetched over two cycles.
- Block fetches the operands, applies the op's sign flips, and holds them stable on the FMADD inputs for FMA_LAT cycles.
- Then captures rd and presents it to writeback with a valid/ready handshake.
- Format: IEEE binary16 (1 sign, 5 exp, 10 mantissa).

Parameters:
- WIDTH, 16, operand/result width.
- AW, 5, register address width.
- FMA_LAT, 1, cycles operands are held on FMADD inputs before result capture (legal 1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready at clk_i rise
- req_op_i  in  2  00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
- req_rs1_i, req_rs2_i, req_rs3_i  in  AW each  source register addresses
- req_rd_i  in  AW  destination register address
- rf_raddr_a_o, rf_raddr_b_o  out  AW  register file read addresses
- rf_rdata_a_i, rf_rdata_b_i  in  WIDTH  read data, combinational, same cycle as address
- fma_rs1_o, fma_rs2_o, fma_rs3_o  out  WIDTH  FMADD operands
- fma_rd_i  in  WIDTH  FMADD result (rs1*rs2+rs3)
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  writeback accepts
- wb_addr_o  out  AW  destination register
- wb_data_o  out  WIDTH  result
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all operand/result/address registers 0, wb_valid_o=0, req_ready_o=1, busy_o=0, rf addresses 0.
- FSM states: IDLE, READ_AB, READ_C, EXEC, WB.
- IDLE:
  - req_ready_o=1; rf addresses 0.
  - On handshake, latch op, rs3 and rd addresses; drive rs1/rs2 addresses next cycle; go to READ_AB.
- READ_AB:
  - rf_raddr_a_o=rs1, rf_raddr_b_o=rs2.
  - At edge, latch op1=rdata_a, op2=rdata_b; go to READ_C.
- READ_C:
  - rf_raddr_a_o=rs3, rf_raddr_b_o=0.
  - At edge, latch op3=rdata_a; clear exec counter; go to EXEC.
- EXEC:
  - fma_rs*_o driven from latched regs, with sign flips:
    - FMSUB inverts op3[15].
    - FNMSUB inverts op1[15].
    - FNMADD inverts op1[15] and op3[15].
  - fma_rs*_o are stable for the full EXEC period and remain stable in WB.
  - Counter runs 0..FMA_LAT-1. On the edge where counter==FMA_LAT-1, capture fma_rd_i into the result register and go to WB.
- WB:
  - wb_valid_o=1; wb_addr_o and wb_data_o held constant while !wb_ready_i.
  - On wb_ready_i, go to IDLE with wb_valid_o=0 next cycle.
- Latency: wb_valid_o rises 2+FMA_LAT cycles after the accept edge (default 3). Throughput: one op per 4+FMA_LAT cycles minimum.
- req_ready_o=0 in every non-IDLE state; requests presented then are ignored, not queued.
- rs1==rs2==rs3 or rd equal to a source: no special handling, reads are independent.
- wb_ready_i high before WB: ignored.
- Reset asserted mid-EXEC or mid-WB: operation is discarded; no wb_valid_o pulse after reset release.

Optional Feature:
- Macro FPU_SEQ_CANON_NAN_EN.
- Defined: at capture, if fma_rd_i[14:10]==5'h1F and fma_rd_i[9:0]!=0, the stored result is 16'h7E00 (canonical NaN, sign cleared).
- Undefined: fma_rd_i is stored unmodified.
- Inf (mantissa 0) is never altered in either build.

Test Plan:
- FMADD, x1=4000 (2.0), x2=4200 (3.0), x3=3C00 (1.0), rd=x5 -> fma inputs 4000/4200/3C00 in EXEC; wb_valid_o 3 cycles after accept; wb_addr_o=5, wb_data_o=4700.
- FMSUB same regs -> fma_rs3_o=BC00, wb_data_o=4500. FNMADD -> fma_rs1_o=C000, fma_rs3_o=BC00, wb_data_o=C700.
- Backpressure: wb_ready_i=0 for 5 cycles in WB -> wb_data_o/wb_addr_o constant, req_ready_o=0, second req_valid_i ignored. After ready, req_ready_o=1 the next cycle.
- FMA_LAT=3 with a stub whose fma_rd_i changes each cycle -> captured value is the one present in the 3rd EXEC cycle; wb_valid_o 5 cycles after accept.
- rst_ni low 1 cycle during EXEC -> all outputs 0 immediately (async); no wb_valid_o afterwards; next request completes normally.
- Stub returns 7D55: with FPU_SEQ_CANON_NAN_EN -> wb_data_o=7E00; without -> 7D55. Stub returns 7C00 -> 7C00 in both builds.
